uart_rx_param: RTL and testbench
================================

Name: uart_rx_param

Overview:
Parametrised successor to the fixed 8N1 UART receiver. Configurable data width, runtime parity mode, per-bit error flags, false-start rejection, and an output FIFO with valid/ready handshake. Sits between the pad-side serial line and the byte consumer, for example a command parser. BR_Clocks keeps its existing meaning: clocks per bit, e.g. 868 gives 115200 baud at 100 MHz.

Parameters:
DATA_W, 8, data bits per frame; legal range 5..9.
FIFO_DEPTH, 4, output FIFO entries; must be a power of 2, minimum 2.
BRW, 15, width of BR_Clocks.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
Rx_Serial  in  1  asynchronous serial line; idles high
BR_Clocks  in  BRW  clocks per bit; minimum 8
Parity_Mode  in  2  00 none, 01 even, 10 odd, 11 none
Rx_Data  out  DATA_W  FIFO head data
Rx_Parity_Err  out  1  FIFO head parity-error tag
Rx_Frame_Err  out  1  FIFO head framing-error tag
Rx_Valid  out  1  FIFO non-empty
Rx_Ready  in  1  consumer accepts the head when Rx_Valid & Rx_Ready
Rx_Overrun  out  1  sticky: a frame was dropped because the FIFO was full
Ovr_Clr  in  1  one-cycle pulse that clears Rx_Overrun
Rx_Busy  out  1  FSM not in IDLE

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE; FIFO empty; all outputs 0; synchroniser flops preset to 1.
- Rx_Serial passes through a 2-FF synchroniser. All references to "line" below mean the synchronised value.
- IDLE: a line value of 0 starts a frame. BR_Clocks and Parity_Mode are latched at this point; changes mid-frame have no effect. Bit counter cleared. Go to START.
- START: sample at count == latched_BR>>1.
  - line=1: false start; return to IDLE, nothing written.
  - line=0: reset count; go to DATA.
- DATA: sample each bit at count == latched_BR-1, LSB first. After DATA_W samples:
  - go to PARITY if the mode is even or odd;
  - otherwise go to STOP.
- PARITY: sample one bit. Even mode: error if XOR(data, parity bit)=1. Odd mode: error if XOR(data, parity bit)=0.
- STOP: sample one bit. line=0 sets the frame error.
  - On this same clock edge the word is written to the FIFO with both error tags.
  - Rx_Valid rises on the next cycle; latency is 1 clk after the stop sample.
  - If the stop bit was 1: go to IDLE.
  - If the stop bit was 0: go to BREAK.
- BREAK: wait until line=1, then go to IDLE. A held-low break produces exactly one word (frame error, data 0).
- FIFO write when full: the word is discarded, Rx_Overrun is set, and FIFO contents are unchanged.
- FIFO read/write rules:
  - Simultaneous write and pop while full: both succeed and no overrun.
  - Simultaneous write and pop while empty: the write lands; Rx_Valid rises next cycle.
- Rx_Overrun: Ovr_Clr clears it. If Ovr_Clr and a new overrun occur in the same cycle, set wins.
- Rx_Data/tag outputs are held stable while Rx_Valid=1 and Rx_Ready=0. They read 0 when the FIFO is empty.
- Counters are BRW bits wide; count never exceeds latched_BR-1 and wraps to 0 at every sample.
- rst_n asserted mid-frame: immediate return to reset state. The partial frame is lost and the FIFO is emptied.

Optional Feature:
RX_MAJORITY_VOTE_EN:
- Defined: every sample (start, data, parity, stop) is a 2-of-3 majority of the line at count-1, count and count+1 around the sample point.
- Not defined: a single sample is taken at the sample point. The interface is identical in both builds.

Test Plan:
- BR_Clocks=868, Parity_Mode=00, send all 256 bytes 8N1 with Rx_Ready=1 -> each Rx_Data equals the sent byte; Rx_Valid pulses once per frame; error tags are 0.
- Parity_Mode=01, send 0x03 with parity bit 1 -> Rx_Data=0x03, Rx_Parity_Err=1. Resend with parity bit 0 -> Rx_Parity_Err=0. Repeat with Parity_Mode=10 and check the inverted result.
- Send 0x55 with stop bit 0, then hold the line low for 20 bit times -> exactly one word: 0x55 with Rx_Frame_Err=1. A following good frame of 0xAA is received cleanly.
- Drive a 100-clk low glitch on an idle line (BR=868) -> no word written; Rx_Busy returns to 0 within 435 clks.
- Rx_Ready=0, send 0x01..0x05 with FIFO_DEPTH=4 -> Rx_Overrun=1; pops return 0x01..0x04; Ovr_Clr clears Rx_Overrun.
- Assert rst_n=0 during data bit 3 of a frame, then release and send 0x3C -> all outputs 0 during reset; the next word is 0x3C only.

Source files
------------

// File: rtl/uart_rx_param_if.sv
// Receive-side word handshake between uart_rx_param and its consumer.
interface uart_rx_param_if #(
    parameter int unsigned DATA_W = 8
);
    logic [DATA_W-1:0] Rx_Data;
    logic              Rx_Parity_Err;
    logic              Rx_Frame_Err;
    logic              Rx_Valid;
    logic              Rx_Ready;

    modport master (
        output Rx_Data, Rx_Parity_Err, Rx_Frame_Err, Rx_Valid,
        input  Rx_Ready
    );

    modport slave (
        input  Rx_Data, Rx_Parity_Err, Rx_Frame_Err, Rx_Valid,
        output Rx_Ready
    );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: runtime parity, error tags, false-start rejection, output FIFO.
// Optional macro RX_MAJORITY_VOTE_EN: 2-of-3 majority vote around every sample point.
module uart_rx_param #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned BRW        = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Rx_Serial,
    input  logic [BRW-1:0]    BR_Clocks,
    input  logic [1:0]        Parity_Mode,
    uart_rx_param_if.master   rx_if,
    output logic              Rx_Overrun,
    input  logic              Ovr_Clr,
    output logic              Rx_Busy
);
    localparam int unsigned BCW = $clog2(DATA_W);
    localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam int unsigned EW  = DATA_W + 2;

    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_BREAK
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        sync_q, sync_d;
    logic [BRW-1:0]    count_q, count_d;
    logic [BRW-1:0]    br_q, br_d;
    logic [1:0]        mode_q, mode_d;
    logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              pe_q, pe_d;
    logic [EW-1:0]     mem_q [FIFO_DEPTH];
    logic [EW-1:0]     mem_d [FIFO_DEPTH];
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              valid_q, valid_d;
    logic              ovr_q, ovr_d;
    logic              busy_q, busy_d;

    logic              line_c, samp_c, wr_c, wr_fe_c, pop_c, ovr_set_c, par_en_c;
    logic [BRW-1:0]    count_inc_c, br_m1_c;
    logic [EW-1:0]     entry_c;

    assign sync_d = {sync_q[0], Rx_Serial};

`ifdef RX_MAJORITY_VOTE_EN
    // FSM runs one clock behind the newest sample so the vote spans count-1..count+1.
    logic [1:0] hist_q, hist_d;
    assign hist_d = {hist_q[0], sync_q[1]};
    assign line_c = hist_q[0];
    assign samp_c = (hist_q[1] & hist_q[0]) | (hist_q[1] & sync_q[1]) | (hist_q[0] & sync_q[1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hist_q <= 2'b11;
        else        hist_q <= hist_d;
    end
`else
    assign line_c = sync_q[1];
    assign samp_c = sync_q[1];
`endif

    assign count_inc_c = count_q + BRW'(1);
    assign br_m1_c     = br_q - BRW'(1);
    assign par_en_c    = mode_q[0] ^ mode_q[1];

    // Frame FSM: next state, counters and FIFO write request.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        br_d      = br_q;
        mode_d    = mode_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        pe_d      = pe_q;
        wr_c      = 1'b0;
        wr_fe_c   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!line_c) begin
                    br_d      = BR_Clocks;
                    mode_d    = Parity_Mode;
                    count_d   = '0;
                    bit_cnt_d = '0;
                    pe_d      = 1'b0;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                if (count_q == (br_q >> 1)) begin
                    count_d = '0;
                    state_d = samp_c ? ST_IDLE : ST_DATA;
                end else begin
                    count_d = count_inc_c;
                end
            end
            ST_DATA: begin
                if (count_q == br_m1_c) begin
                    count_d   = '0;
                    shift_d   = {samp_c, shift_q[DATA_W-1:1]};
                    bit_cnt_d = bit_cnt_q + BCW'(1);
                    if (bit_cnt_q == BCW'(DATA_W - 1)) begin
                        state_d = par_en_c ? ST_PARITY : ST_STOP;
                    end
                end else begin
                    count_d = count_inc_c;
                end
            end
            ST_PARITY: begin
                if (count_q == br_m1_c) begin
                    count_d = '0;
                    // Odd mode (10) inverts the even-parity error sense.
                    pe_d    = (^shift_q) ^ samp_c ^ mode_q[1];
                    state_d = ST_STOP;
                end else begin
                    count_d = count_inc_c;
                end
            end
            ST_STOP: begin
                if (count_q == br_m1_c) begin
                    count_d = '0;
                    wr_c    = 1'b1;
                    wr_fe_c = ~samp_c;
                    state_d = samp_c ? ST_IDLE : ST_BREAK;
                end else begin
                    count_d = count_inc_c;
                end
            end
            ST_BREAK: begin
                if (line_c) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign entry_c = {wr_fe_c, pe_q, shift_q};
    assign pop_c   = valid_q & rx_if.Rx_Ready;

    // Shift-style FIFO: entry 0 is always the head, unused entries are kept at zero.
    always_comb begin
        mem_d     = mem_q;
        cnt_d     = cnt_q;
        ovr_set_c = 1'b0;
        if (pop_c) begin
            for (int unsigned i = 0; i < FIFO_DEPTH - 1; i++) begin
                mem_d[AW'(i)] = mem_q[AW'(i + 1)];
            end
            mem_d[AW'(FIFO_DEPTH - 1)] = '0;
            cnt_d = cnt_q - CW'(1);
        end
        if (wr_c) begin
            if (cnt_d == CW'(FIFO_DEPTH)) begin
                ovr_set_c = 1'b1;
            end else begin
                for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                    if (CW'(i) == cnt_d) mem_d[AW'(i)] = entry_c;
                end
                cnt_d = cnt_d + CW'(1);
            end
        end
        valid_d = (cnt_d != '0);
        ovr_d   = (ovr_q & ~Ovr_Clr) | ovr_set_c;
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            sync_q    <= 2'b11;
            count_q   <= '0;
            br_q      <= '0;
            mode_q    <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            pe_q      <= 1'b0;
            mem_q     <= '{default: '0};
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            ovr_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            count_q   <= count_d;
            br_q      <= br_d;
            mode_q    <= mode_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            pe_q      <= pe_d;
            mem_q     <= mem_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            ovr_q     <= ovr_d;
            busy_q    <= busy_d;
        end
    end

    assign rx_if.Rx_Data       = mem_q[0][DATA_W-1:0];
    assign rx_if.Rx_Parity_Err = mem_q[0][DATA_W];
    assign rx_if.Rx_Frame_Err  = mem_q[0][DATA_W+1];
    assign rx_if.Rx_Valid      = valid_q;
    assign Rx_Overrun          = ovr_q;
    assign Rx_Busy             = busy_q;
endmodule

// File: tb/tb_uart_rx_param.sv
// Directed testbench for uart_rx_param (8-bit data, 4-entry FIFO).
module tb_uart_rx_param;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Rx_Serial = 1'b1;
    logic [14:0] BR_Clocks = 15'd16;
    logic [1:0]  Parity_Mode = 2'b00;
    logic        Rx_Overrun;
    logic        Ovr_Clr = 1'b0;
    logic        Rx_Busy;

    int checks = 0;
    int errors = 0;
    logic [9:0] rxq[$];

    uart_rx_param_if #(.DATA_W(8)) rx_if ();

    uart_rx_param #(.DATA_W(8), .FIFO_DEPTH(4), .BRW(15)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .Rx_Serial   (Rx_Serial),
        .BR_Clocks   (BR_Clocks),
        .Parity_Mode (Parity_Mode),
        .rx_if       (rx_if),
        .Rx_Overrun  (Rx_Overrun),
        .Ovr_Clr     (Ovr_Clr),
        .Rx_Busy     (Rx_Busy)
    );

    always #5 clk = ~clk;

    // Every accepted word, as {frame_err, parity_err, data}.
    always @(posedge clk) begin
        if (rst_n && rx_if.Rx_Valid && rx_if.Rx_Ready)
            rxq.push_back({rx_if.Rx_Frame_Err, rx_if.Rx_Parity_Err, rx_if.Rx_Data});
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic drive_bit(input logic b, input int br);
        Rx_Serial = b;
        repeat (br) @(negedge clk);
    endtask

    task automatic idle(input int n);
        Rx_Serial = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input int br, input logic use_par,
                              input logic par_bit, input logic stop_bit);
        drive_bit(1'b0, br);
        for (int i = 0; i < 8; i++) drive_bit(d[i], br);
        if (use_par) drive_bit(par_bit, br);
        drive_bit(stop_bit, br);
        Rx_Serial = 1'b1;
    endtask

    task automatic test_reset();
        rx_if.Rx_Ready = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if ({rx_if.Rx_Data, rx_if.Rx_Parity_Err, rx_if.Rx_Frame_Err, rx_if.Rx_Valid,
             Rx_Overrun, Rx_Busy} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs: got data=%h pe=%b fe=%b v=%b ovr=%b busy=%b expected all 0",
                     rx_if.Rx_Data, rx_if.Rx_Parity_Err, rx_if.Rx_Frame_Err, rx_if.Rx_Valid,
                     Rx_Overrun, Rx_Busy);
        end
        rst_n = 1'b1;
        idle(4);
    endtask

    task automatic test_all_bytes();
        BR_Clocks = 15'd16;
        Parity_Mode = 2'b00;
        rx_if.Rx_Ready = 1'b1;
        rxq.delete();
        for (int b = 0; b < 256; b++) send_frame(8'(b), 16, 1'b0, 1'b0, 1'b1);
        idle(32);
        checks++;
        if (rxq.size() !== 256) begin
            errors++;
            $display("FAIL all_bytes_count: got %0d words expected 256", rxq.size());
        end
        for (int i = 0; i < 256 && i < rxq.size(); i++) begin
            checks++;
            if (rxq[i] !== {2'b00, 8'(i)}) begin
                errors++;
                $display("FAIL all_bytes[%0d]: got %h expected %h", i, rxq[i], {2'b00, 8'(i)});
            end
        end
    endtask

    task automatic test_parity();
        logic [9:0] exp_w [4];
        exp_w[0] = {2'b01, 8'h03};
        exp_w[1] = {2'b00, 8'h03};
        exp_w[2] = {2'b00, 8'h03};
        exp_w[3] = {2'b01, 8'h03};
        rx_if.Rx_Ready = 1'b1;
        rxq.delete();
        Parity_Mode = 2'b01;
        send_frame(8'h03, 16, 1'b1, 1'b1, 1'b1);
        send_frame(8'h03, 16, 1'b1, 1'b0, 1'b1);
        idle(16);
        Parity_Mode = 2'b10;
        send_frame(8'h03, 16, 1'b1, 1'b1, 1'b1);
        send_frame(8'h03, 16, 1'b1, 1'b0, 1'b1);
        idle(32);
        Parity_Mode = 2'b00;
        checks++;
        if (rxq.size() !== 4) begin
            errors++;
            $display("FAIL parity_count: got %0d words expected 4", rxq.size());
        end
        for (int i = 0; i < 4 && i < rxq.size(); i++) begin
            checks++;
            if (rxq[i] !== exp_w[i]) begin
                errors++;
                $display("FAIL parity[%0d]: got %h expected %h", i, rxq[i], exp_w[i]);
            end
        end
    endtask

    task automatic test_break();
        rx_if.Rx_Ready = 1'b1;
        rxq.delete();
        send_frame(8'h55, 16, 1'b0, 1'b0, 1'b0);
        Rx_Serial = 1'b0;
        repeat (20 * 16) @(negedge clk);
        idle(32);
        send_frame(8'hAA, 16, 1'b0, 1'b0, 1'b1);
        idle(32);
        checks++;
        if (rxq.size() !== 2) begin
            errors++;
            $display("FAIL break_count: got %0d words expected 2", rxq.size());
        end
        if (rxq.size() >= 1) begin
            checks++;
            if (rxq[0] !== {2'b10, 8'h55}) begin
                errors++;
                $display("FAIL break_word: got %h expected %h", rxq[0], {2'b10, 8'h55});
            end
        end
        if (rxq.size() >= 2) begin
            checks++;
            if (rxq[1] !== {2'b00, 8'hAA}) begin
                errors++;
                $display("FAIL after_break_word: got %h expected %h", rxq[1], {2'b00, 8'hAA});
            end
        end
    endtask

    task automatic test_false_start();
        int k;
        BR_Clocks = 15'd868;
        rx_if.Rx_Ready = 1'b1;
        rxq.delete();
        idle(10);
        Rx_Serial = 1'b0;
        repeat (100) @(negedge clk);
        Rx_Serial = 1'b1;
        checks++;
        if (Rx_Busy !== 1'b1) begin
            errors++;
            $display("FAIL glitch_busy_high: got %b expected 1", Rx_Busy);
        end
        k = 0;
        while (Rx_Busy === 1'b1 && k < 435) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (Rx_Busy !== 1'b0) begin
            errors++;
            $display("FAIL glitch_busy_timeout: got busy=%b after %0d clks expected 0", Rx_Busy, k);
        end
        idle(20);
        checks++;
        if (rxq.size() !== 0 || rx_if.Rx_Valid !== 1'b0) begin
            errors++;
            $display("FAIL glitch_no_word: got %0d words valid=%b expected 0 words valid=0",
                     rxq.size(), rx_if.Rx_Valid);
        end
        BR_Clocks = 15'd16;
    endtask

    task automatic test_overrun();
        rx_if.Rx_Ready = 1'b0;
        rxq.delete();
        for (int b = 1; b <= 5; b++) send_frame(8'(b), 16, 1'b0, 1'b0, 1'b1);
        idle(32);
        checks++;
        if (Rx_Overrun !== 1'b1 || rx_if.Rx_Valid !== 1'b1 || rx_if.Rx_Data !== 8'h01) begin
            errors++;
            $display("FAIL overrun_set: got ovr=%b valid=%b head=%h expected 1 1 01",
                     Rx_Overrun, rx_if.Rx_Valid, rx_if.Rx_Data);
        end
        rx_if.Rx_Ready = 1'b1;
        repeat (8) @(negedge clk);
        rx_if.Rx_Ready = 1'b0;
        checks++;
        if (rxq.size() !== 4) begin
            errors++;
            $display("FAIL overrun_pops: got %0d words expected 4", rxq.size());
        end
        for (int i = 0; i < 4 && i < rxq.size(); i++) begin
            checks++;
            if (rxq[i] !== {2'b00, 8'(i + 1)}) begin
                errors++;
                $display("FAIL overrun_word[%0d]: got %h expected %h", i, rxq[i], {2'b00, 8'(i + 1)});
            end
        end
        checks++;
        if (Rx_Overrun !== 1'b1 || rx_if.Rx_Valid !== 1'b0 || rx_if.Rx_Data !== 8'h00) begin
            errors++;
            $display("FAIL overrun_sticky: got ovr=%b valid=%b data=%h expected 1 0 00",
                     Rx_Overrun, rx_if.Rx_Valid, rx_if.Rx_Data);
        end
        Ovr_Clr = 1'b1;
        @(negedge clk);
        Ovr_Clr = 1'b0;
        checks++;
        if (Rx_Overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_clear: got %b expected 0", Rx_Overrun);
        end
    endtask

    task automatic test_midframe_reset();
        logic [7:0] d;
        d = 8'hA5;
        rx_if.Rx_Ready = 1'b0;
        rxq.delete();
        send_frame(8'h11, 16, 1'b0, 1'b0, 1'b1);
        idle(32);
        checks++;
        if (rx_if.Rx_Valid !== 1'b1 || rx_if.Rx_Data !== 8'h11) begin
            errors++;
            $display("FAIL pre_reset_head: got valid=%b data=%h expected 1 11",
                     rx_if.Rx_Valid, rx_if.Rx_Data);
        end
        drive_bit(1'b0, 16);
        for (int i = 0; i < 3; i++) drive_bit(d[i], 16);
        Rx_Serial = d[3];
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({rx_if.Rx_Data, rx_if.Rx_Parity_Err, rx_if.Rx_Frame_Err, rx_if.Rx_Valid,
             Rx_Overrun, Rx_Busy} !== 13'd0) begin
            errors++;
            $display("FAIL midframe_reset_outputs: got data=%h pe=%b fe=%b v=%b ovr=%b busy=%b expected all 0",
                     rx_if.Rx_Data, rx_if.Rx_Parity_Err, rx_if.Rx_Frame_Err, rx_if.Rx_Valid,
                     Rx_Overrun, Rx_Busy);
        end
        Rx_Serial = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        idle(32);
        rx_if.Rx_Ready = 1'b1;
        send_frame(8'h3C, 16, 1'b0, 1'b0, 1'b1);
        idle(32);
        checks++;
        if (rxq.size() !== 1) begin
            errors++;
            $display("FAIL post_reset_count: got %0d words expected 1", rxq.size());
        end
        if (rxq.size() >= 1) begin
            checks++;
            if (rxq[0] !== {2'b00, 8'h3C}) begin
                errors++;
                $display("FAIL post_reset_word: got %h expected %h", rxq[0], {2'b00, 8'h3C});
            end
        end
    endtask

    initial begin
        test_reset();
        test_all_bytes();
        test_parity();
        test_break();
        test_false_start();
        test_overrun();
        test_midframe_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
